// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: single-ported memory bus shared by the fetch and data ports
//   master : req, we, addr (word), wdata, be driven; ready, valid, rdata received
//   slave  : the memory side of the same bus
interface mem_port_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic        valid;
    logic [31:0] rdata;
    modport master (output req, we, addr, wdata, be, input ready, valid, rdata);
    modport slave  (input req, we, addr, wdata, be, output ready, valid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between fetch and data requesters
//   clk, rst_n                  : clock, asynchronous active-low reset
//   im_req/im_addr/im_flush     : fetch request, byte address, cancel pulse
//   im_valid/im_data            : fetch response pulse and instruction word
//   dm_req/dm_we/dm_addr/...    : data load/store request (wdata, be)
//   dm_valid/dm_rdata           : data response pulse and load data (0 after store)
//   mem                         : memory bus master (one outstanding request)
module mem_port_arbiter #(
    parameter int ADDR_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        im_req,
    input  logic [31:0] im_addr,
    input  logic        im_flush,
    output logic        im_valid,
    output logic [31:0] im_data,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    mem_port_arbiter_if.master mem
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t      state, state_nx;
    logic        owner_d, last_d, last_d_nx, drop, drop_nx;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_be;
    logic        fetch_ok, grant_any, grant_d, cancel_i, deliver;
    // a flush in IDLE keeps the fetch out of arbitration for that cycle
    assign fetch_ok  = im_req & ~im_flush;
    assign grant_any = dm_req | fetch_ok;
    // on a conflict the side that did not win last time gets the port
    assign grant_d   = dm_req & (~fetch_ok | ~last_d);
    assign cancel_i  = ~owner_d & im_flush;
    assign deliver   = (state == WAIT) & mem.valid & ~drop & ~cancel_i;
    always_comb begin
        state_nx  = state;
        drop_nx   = drop;
        last_d_nx = last_d;
        case (state)
            IDLE:  state_nx = grant_any ? ISSUE : IDLE;
            ISSUE: begin
                if (mem.ready) begin
                    state_nx  = WAIT;
                    last_d_nx = owner_d;
                    drop_nx   = cancel_i;
                end else if (cancel_i) begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                drop_nx = drop | cancel_i;
                if (mem.valid) begin
                    state_nx = (drop | cancel_i) ? IDLE : RESP;
                    drop_nx  = 1'b0;
                end
            end
            RESP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            drop   <= 1'b0;
            last_d <= 1'b0;
        end else begin
            state  <= state_nx;
            drop   <= drop_nx;
            last_d <= last_d_nx;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_d   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            im_data   <= '0;
            dm_rdata  <= '0;
        end else begin
            if (state == IDLE && grant_any) begin
                owner_d   <= grant_d;
                lat_we    <= grant_d & dm_we;
                lat_addr  <= grant_d ? dm_addr : im_addr;
                lat_wdata <= grant_d ? dm_wdata : '0;
                lat_be    <= (grant_d & dm_we) ? dm_be : 4'hF;
            end
            if (deliver && owner_d)
                dm_rdata <= lat_we ? '0 : mem.rdata;
            if (deliver && !owner_d)
                im_data <= mem.rdata;
        end
    end
    assign mem.req   = (state == ISSUE);
    assign mem.we    = lat_we;
    assign mem.addr  = lat_addr >> ADDR_SHIFT;
    assign mem.wdata = lat_wdata;
    assign mem.be    = lat_be;
    // a flush landing on the response cycle still suppresses the fetch pulse
    assign im_valid  = (state == RESP) & ~owner_d & ~im_flush;
    assign dm_valid  = (state == RESP) & owner_d;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- One transaction is outstanding at a time. A registered FSM sequences each one: arbitrate, issue, wait for response, return.
- Round-robin arbitration prevents fetch starvation during load/store bursts.
- Supports a fetch flush: a branch or PC redirect discards an in-flight fetch.

Parameters:
- ADDR_SHIFT, 2, right-shift applied to requester byte addresses to form the memory word address.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- im_req  in  1  fetch request; held with im_addr stable until im_valid or im_flush
- im_addr  in  32  fetch byte address
- im_flush  in  1  one-cycle pulse; cancels the pending or in-flight fetch
- im_valid  out  1  one-cycle pulse; im_data is valid
- im_data  out  32  fetched instruction
- dm_req  in  1  data request; held with all dm_* inputs stable until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_be  in  4  store byte enables
- dm_valid  out  1  one-cycle pulse; load data valid, or store done
- dm_rdata  out  32  load data (0 after a store)
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address = latched byte address >> ADDR_SHIFT
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables (4'hF for fetch and load)
- mem_ready  in  1  memory accepts the request this cycle
- mem_valid  in  1  response/ack; one pulse per accepted request
- mem_rdata  in  32  read data, qualified by mem_valid

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. All registers reset asynchronously.
- Reset values: state=IDLE; all outputs 0; last_grant=I; drop=0.
- IDLE:
  - If any request is present, latch owner, address, we, wdata and be, then go to ISSUE.
  - Both requests present: grant the opposite of last_grant. After reset, data therefore wins the first conflict.
  - One request present: grant it.
  - im_flush in IDLE blocks the fetch grant that cycle.
- ISSUE:
  - mem_req=1; mem_* driven from the latched values (combinational from the registers).
  - mem_ready=1 → WAIT, and last_grant←owner.
  - If owner=I and im_flush=1 while mem_ready=0 → IDLE; the request is withdrawn with no memory access.
  - If im_flush=1 and mem_ready=1 in the same cycle → WAIT with drop=1.
- WAIT:
  - mem_req=0.
  - im_flush while owner=I sets drop=1.
  - On mem_valid: register mem_rdata into the owner's data output (dm_rdata←0 for stores) and go to RESP.
  - If drop=1, go to IDLE instead, clear drop, and produce no valid pulse.
- RESP:
  - The owner's valid is high for exactly one cycle. Next state is IDLE.
  - No arbitration happens in RESP, so the requester may drop or replace its request in this cycle.
  - im_valid = resp_i & ~im_flush; a flush in the RESP cycle suppresses the pulse.
- Latency:
  - Request seen in IDLE at cycle n.
  - mem_req at n+1.
  - With mem_ready=1 and mem_valid at n+2, valid is at n+3.
  - Minimum 4 cycles per transaction; throughput 1 per 4 cycles.
- im_valid and dm_valid are never high in the same cycle.
- At most one outstanding memory request.
- mem_valid outside WAIT is ignored; this covers stale responses after a reset.
- Reset mid-transaction returns immediately to IDLE with outputs cleared. Any later response is ignored.
- Data-side requests are never cancelled.
- im_data and dm_rdata hold their last value between pulses.

Test Plan:
- Single fetch:
  - Stimulus: im_req=1, im_addr=0x0000_0010, memory answers 1 cycle after mem_ready with 0x0000_0013.
  - Response: mem_addr=0x4, mem_be=4'hF, mem_we=0; im_valid one cycle with im_data=0x0000_0013 at cycle n+3.
- Contention:
  - Stimulus: im_req and dm_req (load, 0x100) held together from reset.
  - Response: grant order D, I, D, I; mem_addr alternates 0x40 and the fetch word address; never two valids in one cycle.
- Store:
  - Stimulus: dm_we=1, dm_addr=0x8, dm_wdata=0xDEADBEEF, dm_be=4'b0011, mem_ready delayed 3 cycles.
  - Response: mem_req held high 4 cycles with stable fields; dm_valid pulse with dm_rdata=0.
- Flush in WAIT:
  - Stimulus: fetch accepted, im_flush pulsed before mem_valid.
  - Response: no im_valid; FSM back in IDLE the cycle after mem_valid. A following fetch to 0x20 completes normally.
- Flush in ISSUE with mem_ready=0:
  - Response: mem_req drops next cycle; no memory transaction.
  - Stimulus: a late mem_valid pulse.
  - Response: ignored.
- Reset mid-WAIT:
  - Stimulus: rst_n low one cycle, then mem_valid arrives.
  - Response: all outputs 0 immediately, no valid pulse, state IDLE.
